// File: rtl/opentdc_wb_arb.sv
// Two-master round-robin Wishbone arbiter for the opentdc_wb slave port.
// One classic-cycle transaction at a time, with a bus timeout and a sticky timeout flag.
module opentdc_wb_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_o,
  input  logic        timeout_clr_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        last, last_next;
  logic [7:0]  cnt, cnt_next;
  logic        timeout_flag;
  logic        tmo_event;
  logic        gcyc;
  logic        req0, req1;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Next-state, grant history and timeout counter.
  always_comb begin
    state_next = state;
    last_next  = last;
    cnt_next   = cnt;
    tmo_event  = 1'b0;
    gcyc       = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = 8'd0;
        if (req0 && (!req1 || last)) begin
          state_next = GNT0;
          last_next  = 1'b0;
        end else if (req1) begin
          state_next = GNT1;
          last_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      GNT0, GNT1: begin
        gcyc = (state == GNT0) ? m0_cyc_i : m1_cyc_i;
        if (!gcyc || s_ack_i) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          // Ack in the same cycle would have taken the branch above: ack wins.
          tmo_event  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slave-side mux and per-master response routing.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'd0;
    s_adr_o  = 32'd0;
    s_dat_o  = 32'd0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = 32'd0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = 32'd0;
    gnt_o    = 2'b00;
    case (state)
      GNT0: begin
        gnt_o    = 2'b01;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        m0_err_o = tmo_event;
        if (m0_cyc_i) begin
          s_cyc_o = 1'b1;
          s_stb_o = m0_stb_i;
          s_we_o  = m0_we_i;
          s_sel_o = m0_sel_i;
          s_adr_o = m0_adr_i;
          s_dat_o = m0_dat_i;
        end else begin
          s_cyc_o = 1'b0;
        end
      end
      GNT1: begin
        gnt_o    = 2'b10;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        m1_err_o = tmo_event;
        if (m1_cyc_i) begin
          s_cyc_o = 1'b1;
          s_stb_o = m1_stb_i;
          s_we_o  = m1_we_i;
          s_sel_o = m1_sel_i;
          s_adr_o = m1_adr_i;
          s_dat_o = m1_dat_i;
        end else begin
          s_cyc_o = 1'b0;
        end
      end
      default: begin
        gnt_o = 2'b00;
      end
    endcase
  end

  // State, grant history and timeout counter registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      last  <= last_next;
      cnt   <= cnt_next;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      timeout_flag <= 1'b0;
    end else if (tmo_event) begin
      timeout_flag <= 1'b1;
    end else if (timeout_clr_i) begin
      timeout_flag <= 1'b0;
    end else begin
      timeout_flag <= timeout_flag;
    end
  end

  assign timeout_o = timeout_flag;

endmodule

// File: tb/tb_opentdc_wb_arb.sv
// Directed self-checking bench for opentdc_wb_arb (TIMEOUT = 4).
module tb_opentdc_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        tmo, tmo_clr;
  logic [1:0]  gnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  opentdc_wb_arb #(.TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .timeout_o(tmo), .timeout_clr_i(tmo_clr), .gnt_o(gnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = 32'h0; m0_wdat = 32'h0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = 32'h0; m1_wdat = 32'h0;
    s_ack = 1'b0; s_rdat = 32'h0; tmo_clr = 1'b0;
  endtask

  logic [1:0] rr_exp [8];

  initial begin
    rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    rst = 1'b1;
    idle_all();
    #2;
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_scyc", {31'd0, s_cyc}, 32'd0);
    check("rst_tmo", {31'd0, tmo}, 32'd0);
    check("rst_m0ack", {31'd0, m0_ack}, 32'd0);
    tick();
    rst = 1'b0;

    // Single read by m0, slave acks two cycles after strobe.
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_sel = 4'hF; m0_adr = 32'h3000_0004;
    settle();
    check("rd_idle_gnt", {30'd0, gnt}, 32'd0);
    tick(); settle();
    check("rd_gnt", {30'd0, gnt}, 32'h1);
    check("rd_sstb", {31'd0, s_stb}, 32'd1);
    check("rd_sadr", s_adr, 32'h3000_0004);
    check("rd_ssel", {28'd0, s_sel}, 32'hF);
    check("rd_m0ack_early", {31'd0, m0_ack}, 32'd0);
    tick(); settle();
    check("rd_wait_gnt", {30'd0, gnt}, 32'h1);
    tick();
    s_ack = 1'b1; s_rdat = 32'h1234_5678;
    settle();
    check("rd_m0ack", {31'd0, m0_ack}, 32'd1);
    check("rd_m0dat", m0_rdat, 32'h1234_5678);
    check("rd_m1ack", {31'd0, m1_ack}, 32'd0);
    check("rd_m1dat", m1_rdat, 32'd0);
    tick();
    idle_all();
    settle();
    check("rd_after_gnt", {30'd0, gnt}, 32'd0);

    // Round-robin after reset with continuous requests and immediate acks.
    tick();
    rst = 1'b1; #1; rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    settle();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        tick(); settle();
      end
      check($sformatf("rr_gnt%0d", i), {30'd0, gnt}, {30'd0, rr_exp[i]});
    end
    tick();
    idle_all();
    tick();

    // m1 write, slave never acks: timeout after 4 granted cycles.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h3000_0010; m1_wdat = 32'hA5A5_0001;
    settle();
    for (int i = 1; i <= 4; i++) begin
      tick(); settle();
      check($sformatf("to_sstb%0d", i), {31'd0, s_stb}, 32'd1);
      check($sformatf("to_err%0d", i), {31'd0, m1_err}, (i == 4) ? 32'd1 : 32'd0);
    end
    check("to_swe", {31'd0, s_we}, 32'd1);
    check("to_sdat", s_wdat, 32'hA5A5_0001);
    tick(); settle();
    check("to_after_sstb", {31'd0, s_stb}, 32'd0);
    check("to_flag", {31'd0, tmo}, 32'd1);
    check("to_after_err", {31'd0, m1_err}, 32'd0);
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    settle();
    check("clr_flag", {31'd0, tmo}, 32'd0);
    check("clr_regnt", {30'd0, gnt}, 32'h2);
    tick(); tick(); tick();
    tmo_clr = 1'b1;
    settle();
    check("clr_race_err", {31'd0, m1_err}, 32'd1);
    tick();
    tmo_clr = 1'b0;
    idle_all();
    settle();
    check("clr_race_flag", {31'd0, tmo}, 32'd1);
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    settle();
    check("clr_again", {31'd0, tmo}, 32'd0);

    // Ack arrives in the same cycle the timeout would fire.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick(); tick(); tick(); tick();
    s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
    settle();
    check("race_ack", {31'd0, m1_ack}, 32'd1);
    check("race_dat", m1_rdat, 32'hCAFE_F00D);
    check("race_err", {31'd0, m1_err}, 32'd0);
    tick();
    idle_all();
    settle();
    check("race_flag", {31'd0, tmo}, 32'd0);
    check("race_gnt", {30'd0, gnt}, 32'd0);

    // m0 aborts in its 2nd granted cycle; pending m1 follows two cycles later.
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick(); settle();
    check("ab_gnt0", {30'd0, gnt}, 32'h1);
    check("ab_scyc1", {31'd0, s_cyc}, 32'd1);
    tick();
    m0_cyc = 1'b0;
    settle();
    check("ab_scyc_drop", {31'd0, s_cyc}, 32'd0);
    check("ab_sstb_drop", {31'd0, s_stb}, 32'd0);
    tick();
    m0_stb = 1'b0;
    settle();
    check("ab_idle", {30'd0, gnt}, 32'd0);
    tick(); settle();
    check("ab_gnt1", {30'd0, gnt}, 32'h2);
    s_ack = 1'b1;
    settle();
    check("ab_m1ack", {31'd0, m1_ack}, 32'd1);
    tick();
    idle_all();

    // Asynchronous reset while m0 is granted.
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick(); settle();
    check("rm_gnt0", {30'd0, gnt}, 32'h1);
    #2;
    rst = 1'b1; s_ack = 1'b1;
    #1;
    check("rm_scyc", {31'd0, s_cyc}, 32'd0);
    check("rm_gnt", {30'd0, gnt}, 32'd0);
    check("rm_m0ack", {31'd0, m0_ack}, 32'd0);
    check("rm_m0err", {31'd0, m0_err}, 32'd0);
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
    rst = 1'b0;
    settle();
    check("rm_idle", {30'd0, gnt}, 32'd0);
    tick(); settle();
    check("rm_tie_m0", {30'd0, gnt}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/opentdc_wb_arb.md
# opentdc_wb_arb

Two-master Wishbone arbiter in front of the single `opentdc_wb` slave port in the user project wrapper. Master 0 is the Caravel management-core Wishbone bus. Master 1 is a local sequencer that reads TDC results without CPU involvement. Arbitration is round-robin with one outstanding classic-cycle transaction, a bus timeout that frees the slave if it never acknowledges, and a sticky timeout flag for software.

## Interface
Parameters:
- `TIMEOUT`, 255: number of granted cycles without `s_ack_i` before the transaction is aborted. Legal range 1..255; the counter is 8 bits.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, asynchronous and active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 control.
- `m0_sel_i` in 4, `m0_adr_i` in 32, `m0_dat_i` in 32: master 0 byte select, address, write data.
- `m0_ack_o`, `m0_err_o` out 1 each, `m0_dat_o` out 32: master 0 response.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each, `s_sel_o` out 4, `s_adr_o` out 32, `s_dat_o` out 32: to the slave.
- `s_ack_i` in 1, `s_dat_i` in 32: from the slave.
- `timeout_o` out 1: sticky flag, set on any timeout abort.
- `timeout_clr_i` in 1: clears `timeout_o`.
- `gnt_o` out 2: current grant, one-hot; 00 when idle.

## Operation
- A request from master n is `mn_cyc_i & mn_stb_i`.
- States: IDLE, GNT0, GNT1.
  - IDLE to GNTn when master n requests and the other master does not.
  - IDLE with both masters requesting goes to the master that does not hold `last`.
  - GNTn to IDLE on `s_ack_i`, on timeout, or when `mn_cyc_i` drops (abort).
- `last` (1 bit) records the most recently granted master. It is updated on every IDLE to GNTn transition and resets to 1, so master 0 wins the first tie.
- In GNTn:
  - All `s_*` outputs are combinationally equal to master n's inputs.
  - `mn_ack_o` equals `s_ack_i`.
  - `mn_dat_o` equals `s_dat_i`.
- Outputs forced to 0 in any state:
  - In IDLE, all `s_*` outputs.
  - For a non-granted master, its `ack`, `err` and `dat` outputs.
- Timeout:
  - An 8-bit counter clears on entry to GNTn and increments on each granted cycle without `s_ack_i`.
  - In the granted cycle where the counter equals `TIMEOUT-1` with `s_ack_i` low, the arbiter pulses `mn_err_o` for 1 cycle, sets `timeout_o` and returns to IDLE.
  - If `s_ack_i` and the timeout condition occur in the same cycle, ack wins: no err, no flag.
- `timeout_o` update:
  - `timeout_clr_i` alone clears it.
  - A timeout event in the same cycle as `timeout_clr_i` sets it (set wins).
- Reset values:
  - Every output is 0 and the state is IDLE.
  - `last` is 1 and the counter is 0.
- Asynchronous reset mid-transaction drops `s_cyc_o` immediately. No ack or err is generated for the aborted cycle.

## Timing
- Request first visible in IDLE at cycle N: `gnt_o` and `s_cyc_o`/`s_stb_o` assert at cycle N+1.
- Slave ack at cycle K: master ack at cycle K (zero added latency on the response path). The state is IDLE at K+1, and the earliest next grant is at K+2.
- The minimum cost per transaction is therefore 2 cycles plus the slave latency.
- Timeout with no ack: `s_stb_o` is high for cycles N+1..N+TIMEOUT. `mn_err_o` pulses at N+TIMEOUT, and `timeout_o` is 1 from N+TIMEOUT+1.
- A master dropping `cyc` in GNTn: the `s_*` outputs go to 0 in the same cycle (combinational), and the state is IDLE the next cycle.
- Requests that arrive while the other master is granted wait. Requesters are never starved: after a tie, the winner loses the next tie.

## Test plan
- Single read: m0 reads adr 0x3000_0004 and the slave acks 2 cycles after `s_stb_o` with 0x1234_5678. Required:
  - `gnt_o` = 01 one cycle after the request.
  - `m0_ack_o` with `m0_dat_o` = 0x1234_5678 in the slave-ack cycle.
  - `m1_ack_o` = 0 throughout.
- Tie and round-robin: after reset, m0 and m1 request continuously with 1-cycle slave acks. The grant sequence is m0, m1, m0, m1, ..., with `gnt_o` = 00 for exactly 1 cycle between grants.
- Timeout: `TIMEOUT` = 4, m1 writes and the slave never acks. Required:
  - `s_stb_o` high for 4 cycles.
  - `m1_err_o` pulses in the 4th cycle.
  - `timeout_o` = 1 afterwards.
  - `timeout_clr_i` clears the flag, except in a cycle with a simultaneous new timeout, where it stays 1.
- Ack/timeout race: `TIMEOUT` = 4 and the slave acks in the 4th granted cycle. Required: ack delivered, `m1_err_o` = 0, `timeout_o` stays 0.
- Abort: m0 drops `cyc` in its 2nd granted cycle. Required: `s_cyc_o` = 0 in that same cycle; a pending m1 request is granted 2 cycles later.
- Reset mid-transaction: assert `wb_rst_i` while GNT0 is active. Required: all outputs 0 asynchronously; after release, a tie grants m0 first.
